// File: rtl/calc_frame_receiver.sv
// Receiving end of the calculator serial result link: rebuilds 32-bit frames
// from SIZE-bit chunks, splits them into fields and flags truncated transfers.
module calc_frame_receiver #(
   parameter int SIZE = 4
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            ClkTx,
   input  logic            DinValid,
   input  logic [SIZE-1:0] DataIn,
   output logic [31:0]     FrameOut,
   output logic [7:0]      InA,
   output logic [7:0]      InB,
   output logic [7:0]      AluOut,
   output logic [3:0]      SelOut,
   output logic [3:0]      FlagOut,
   output logic            FrameValid,
   output logic            FrameError,
   output logic            RxBusy
);

   localparam int NUM_CHUNKS = 32 / SIZE;
   localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_CHUNKS - 1);
   localparam logic [CNT_W-1:0] FIRST_CNT = (NUM_CHUNKS > 1) ? CNT_W'(1) : '0;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      DONE,
      DRAIN
   } rxState_t;

   rxState_t         state;
   rxState_t         nextState;
   logic             clkTxQ;
   logic             txEdge;
   logic [31:0]      shiftReg;
   logic [31:0]      shiftNext;
   logic [CNT_W-1:0] chunkCnt;
   logic             doFirst;
   logic             doShift;
   logic             doLoad;
   logic             doError;

   // ClkTx is only a level; a rising edge is a cycle where it is high now
   // but was low on the previous Clk. clkTxQ resets high so a ClkTx that is
   // already high at reset release never looks like an edge.
   assign txEdge = ClkTx & ~clkTxQ;

   // Chunks arrive MSB first, so each new chunk enters at the bottom and the
   // older ones move up. A single-chunk frame simply replaces the register.
   if (SIZE == 32) begin : gWholeFrame
      assign shiftNext = DataIn;
   end else begin : gChunkShift
      assign shiftNext = {shiftReg[31-SIZE:0], DataIn};
   end

   // Next-state decode. Losing DinValid in RECV aborts the frame even on a
   // cycle that also carries a ClkTx edge; that chunk is never counted.
   always_comb begin
      nextState = state;
      doFirst   = 1'b0;
      doShift   = 1'b0;
      doLoad    = 1'b0;
      doError   = 1'b0;
      case (state)
         IDLE: begin
            if (txEdge && DinValid) begin
               doFirst   = 1'b1;
               nextState = (NUM_CHUNKS == 1) ? DONE : RECV;
            end
         end
         RECV: begin
            if (!DinValid) begin
               doError   = 1'b1;
               nextState = IDLE;
            end else if (txEdge) begin
               doShift = 1'b1;
               if (chunkCnt == LAST_CNT) begin
                  nextState = DONE;
               end
            end
         end
         DONE: begin
            doLoad    = 1'b1;
            nextState = DinValid ? DRAIN : IDLE;
         end
         DRAIN: begin
            if (!DinValid) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // State register; any reset, even mid-frame, abandons the transfer.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Datapath: edge history, chunk shifting and counting, and the published
   // frame with its one-cycle valid and error pulses. The published frame is
   // only touched in DONE, so an aborted frame leaves the last good one intact.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         clkTxQ     <= 1'b1;
         shiftReg   <= '0;
         chunkCnt   <= '0;
         FrameOut   <= '0;
         FrameValid <= 1'b0;
         FrameError <= 1'b0;
      end else begin
         clkTxQ     <= ClkTx;
         FrameValid <= doLoad;
         FrameError <= doError;
         if (doFirst) begin
            shiftReg <= shiftNext;
            chunkCnt <= FIRST_CNT;
         end else if (doShift) begin
            shiftReg <= shiftNext;
            chunkCnt <= (chunkCnt == LAST_CNT) ? '0 : chunkCnt + 1'b1;
         end else if (doError) begin
            chunkCnt <= '0;
         end
         if (doLoad) begin
            FrameOut <= shiftReg;
         end
      end
   end

   // Field views of the last complete frame.
   assign InA     = FrameOut[31:24];
   assign InB     = FrameOut[23:16];
   assign AluOut  = FrameOut[15:8];
   assign SelOut  = FrameOut[7:4];
   assign FlagOut = FrameOut[3:0];
   assign RxBusy  = (state == RECV);

endmodule

// File: tb/tb_calc_frame_receiver.sv
// Self-checking bench for calc_frame_receiver: table of frames scored through
// an expected-frame queue, plus hand-written reset, back-to-back and SIZE=8 cases.
module tb_calc_frame_receiver;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        ClkTx, DinValid;
   logic [3:0]  DataIn;
   logic [31:0] FrameOut;
   logic [7:0]  InA, InB, AluOut;
   logic [3:0]  SelOut, FlagOut;
   logic        FrameValid, FrameError, RxBusy;

   logic        ClkTx8, DinValid8;
   logic [7:0]  DataIn8;
   logic [31:0] FrameOut8;
   logic [7:0]  InA8, InB8, AluOut8;
   logic [3:0]  SelOut8, FlagOut8;
   logic        FrameValid8, FrameError8, RxBusy8;

   int tests = 0;
   int fails = 0;
   int cycle = 0;
   int lastRiseCycle = 0;
   int validSeen = 0;
   int errSeen = 0;
   int valid8Seen = 0;
   int err8Seen = 0;
   int busy8Seen = 0;
   logic [31:0] expQ[$];
   logic [31:0] expFrame;
   logic [31:0] lastFrame = 32'h0;

   typedef struct {
      logic [31:0] frame;
      int          chunks;
      int          extra;
   } vec_t;

   vec_t vecs[6];

   calc_frame_receiver #(.SIZE(4)) dut (
      .Clk(Clk), .Reset(Reset), .ClkTx(ClkTx), .DinValid(DinValid), .DataIn(DataIn),
      .FrameOut(FrameOut), .InA(InA), .InB(InB), .AluOut(AluOut), .SelOut(SelOut),
      .FlagOut(FlagOut), .FrameValid(FrameValid), .FrameError(FrameError), .RxBusy(RxBusy)
   );

   calc_frame_receiver #(.SIZE(8)) dut8 (
      .Clk(Clk), .Reset(Reset), .ClkTx(ClkTx8), .DinValid(DinValid8), .DataIn(DataIn8),
      .FrameOut(FrameOut8), .InA(InA8), .InB(InB8), .AluOut(AluOut8), .SelOut(SelOut8),
      .FlagOut(FlagOut8), .FrameValid(FrameValid8), .FrameError(FrameError8), .RxBusy(RxBusy8)
   );

   // Free-running system clock.
   always #5 Clk = ~Clk;

   // Cycle counter used to measure frame latency.
   always @(posedge Clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic waitClocks(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   // Scoreboard side: every FrameValid pops the next expected frame and
   // checks the frame, its fields and the latency from the last chunk edge.
   always @(negedge Clk) begin
      if (FrameValid) begin
         validSeen++;
         if (expQ.size() == 0) begin
            checkOutput("unexpected FrameValid", {31'd0, FrameValid}, 32'd0);
         end else begin
            expFrame = expQ.pop_front();
            checkOutput("FrameOut", FrameOut, expFrame);
            checkOutput("InA", {24'd0, InA}, {24'd0, expFrame[31:24]});
            checkOutput("InB", {24'd0, InB}, {24'd0, expFrame[23:16]});
            checkOutput("AluOut", {24'd0, AluOut}, {24'd0, expFrame[15:8]});
            checkOutput("SelOut", {28'd0, SelOut}, {28'd0, expFrame[7:4]});
            checkOutput("FlagOut", {28'd0, FlagOut}, {28'd0, expFrame[3:0]});
            checkOutput("latency", 32'(cycle - lastRiseCycle), 32'd2);
         end
      end
      if (FrameError) errSeen++;
      if (FrameValid8) valid8Seen++;
      if (FrameError8) err8Seen++;
      if (RxBusy8) busy8Seen++;
   end

   // Drives n chunks of a frame (MSB first) plus extra junk edges at a
   // divide-by-4 ClkTx rate, leaving DinValid high at the end.
   task automatic sendChunks(input logic [31:0] frame, input int n, input int extra);
      DinValid = 1'b1;
      for (int i = 0; i < n + extra; i++) begin
         if (i < n) DataIn = frame[31-4*i -: 4];
         else DataIn = 4'($urandom);
         ClkTx = 1'b0;
         waitClocks(2);
         ClkTx = 1'b1;
         if (i == n - 1) lastRiseCycle = cycle;
         waitClocks(2);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      if (v.chunks == 8) begin
         expQ.push_back(v.frame);
         lastFrame = v.frame;
      end
      sendChunks(v.frame, v.chunks, v.extra);
      DinValid = 1'b0;
      ClkTx = 1'b0;
      waitClocks(6);
   endtask

   initial begin
      int vb;
      int eb;
      ClkTx = 1'b0; DinValid = 1'b0; DataIn = '0;
      ClkTx8 = 1'b0; DinValid8 = 1'b0; DataIn8 = '0;

      vecs[0] = '{frame: 32'h3C054116, chunks: 5, extra: 0};
      vecs[1] = '{frame: 32'h3C054116, chunks: 8, extra: 0};
      vecs[2] = '{frame: 32'hFFFFFFFF, chunks: 8, extra: 0};
      vecs[3] = '{frame: 32'h00000001, chunks: 8, extra: 0};
      vecs[4] = '{frame: 32'hA5A55AA5, chunks: 8, extra: 3};
      vecs[5] = '{frame: 32'h5A5A0FF0, chunks: 8, extra: 0};

      waitClocks(3);
      Reset = 1'b0;
      waitClocks(2);
      checkOutput("reset FrameOut", FrameOut, 32'h0);
      checkOutput("reset FrameValid", {31'd0, FrameValid}, 32'd0);
      checkOutput("reset FrameError", {31'd0, FrameError}, 32'd0);
      checkOutput("reset RxBusy", {31'd0, RxBusy}, 32'd0);

      for (int v = 0; v < 6; v++) begin
         vb = validSeen;
         eb = errSeen;
         applyStimulus(vecs[v]);
         checkOutput($sformatf("vec%0d valid pulses", v), 32'(validSeen - vb), (vecs[v].chunks == 8) ? 32'd1 : 32'd0);
         checkOutput($sformatf("vec%0d error pulses", v), 32'(errSeen - eb), (vecs[v].chunks == 8) ? 32'd0 : 32'd1);
         checkOutput($sformatf("vec%0d FrameOut held", v), FrameOut, lastFrame);
         checkOutput($sformatf("vec%0d RxBusy", v), {31'd0, RxBusy}, 32'd0);
      end

      // Back-to-back frames with DinValid low for a single Clk between them.
      vb = validSeen;
      eb = errSeen;
      expQ.push_back(32'hFFFFFFFF);
      sendChunks(32'hFFFFFFFF, 8, 0);
      DinValid = 1'b0;
      waitClocks(1);
      expQ.push_back(32'h00000001);
      lastFrame = 32'h00000001;
      sendChunks(32'h00000001, 8, 0);
      DinValid = 1'b0;
      ClkTx = 1'b0;
      waitClocks(6);
      checkOutput("b2b valid pulses", 32'(validSeen - vb), 32'd2);
      checkOutput("b2b error pulses", 32'(errSeen - eb), 32'd0);
      checkOutput("b2b FrameOut", FrameOut, 32'h00000001);

      // Asynchronous reset after chunk 4, released while ClkTx is still high.
      vb = validSeen;
      eb = errSeen;
      sendChunks(32'h12345678, 4, 0);
      checkOutput("mid-frame RxBusy", {31'd0, RxBusy}, 32'd1);
      #2;
      Reset = 1'b1;
      #1;
      checkOutput("async reset FrameOut", FrameOut, 32'h0);
      checkOutput("async reset InA", {24'd0, InA}, 32'd0);
      checkOutput("async reset RxBusy", {31'd0, RxBusy}, 32'd0);
      checkOutput("async reset FrameValid", {31'd0, FrameValid}, 32'd0);
      checkOutput("async reset FrameError", {31'd0, FrameError}, 32'd0);
      waitClocks(2);
      Reset = 1'b0;
      waitClocks(3);
      checkOutput("no edge at release RxBusy", {31'd0, RxBusy}, 32'd0);
      DinValid = 1'b0;
      ClkTx = 1'b0;
      waitClocks(3);
      checkOutput("reset release valid pulses", 32'(validSeen - vb), 32'd0);
      checkOutput("reset release error pulses", 32'(errSeen - eb), 32'd0);
      lastFrame = 32'h0;
      applyStimulus('{frame: 32'h12345678, chunks: 8, extra: 0});
      checkOutput("post-reset FrameOut", FrameOut, 32'h12345678);
      checkOutput("post-reset valid pulses", 32'(validSeen - vb), 32'd1);

      // SIZE=8 receiver: four byte chunks, then ClkTx parked high.
      DinValid8 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         DataIn8 = 8'(8'h12 + 8'h22 * i);
         ClkTx8 = 1'b0;
         waitClocks(2);
         ClkTx8 = 1'b1;
         waitClocks(2);
      end
      DinValid8 = 1'b0;
      waitClocks(6);
      checkOutput("size8 FrameOut", FrameOut8, 32'h12345678);
      checkOutput("size8 fields", {InA8, InB8, AluOut8, SelOut8, FlagOut8}, 32'h12345678);
      checkOutput("size8 valid pulses", 32'(valid8Seen), 32'd1);
      checkOutput("size8 error pulses", 32'(err8Seen), 32'd0);
      busy8Seen = 0;
      DinValid8 = 1'b1;
      waitClocks(10);
      checkOutput("size8 no-edge RxBusy cycles", 32'(busy8Seen), 32'd0);
      checkOutput("size8 no-edge valid pulses", 32'(valid8Seen), 32'd1);
      DinValid8 = 1'b0;
      waitClocks(3);

      checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Guard against a stuck run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
